// File: rtl/array_scan_reader_pkg.sv
// ---------------------------------------------------------------------------
// array_scan_pkg
// Shared types and width helpers for the array scan reader.
//   scan_state_e : scan FSM states
//   idx_w/cnt_w  : index width and count width (count must hold DEPTH itself)
// ---------------------------------------------------------------------------
package array_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } scan_state_e;

    localparam int DEF_DEPTH = 32;
    localparam int DEF_DSIZE = 32;
    localparam int DEF_IDX_W = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W = DEF_IDX_W + 1;

    function automatic int idx_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // One extra bit so a full-array scan (count == DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return idx_w(depth) + 1;
    endfunction

endpackage

// File: rtl/array_scan_reader_if.sv
// ---------------------------------------------------------------------------
// array_scan_reader_if
// Bundles the write port, scan control and the valid/ready output stream.
//   master : table writer / scan requester / downstream consumer side
//   slave  : the array_scan_reader block
// ---------------------------------------------------------------------------
interface array_scan_reader_if
    import array_scan_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DSIZE = DEF_DSIZE
);
    localparam int IW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    // write port
    logic             wr_en;
    logic [IW-1:0]    wr_addr;
    logic [DSIZE-1:0] wr_data;
    // scan control
    logic             start;
    logic [IW-1:0]    start_idx;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    // output stream
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] out_data;
    logic [IW-1:0]    out_idx;
    logic             out_last;

    modport master (
        output wr_en, wr_addr, wr_data,
        output start, start_idx, count,
        output out_ready,
        input  busy, done,
        input  out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  start, start_idx, count,
        input  out_ready,
        output busy, done,
        output out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/array_scan_reader_regfile.sv
// ---------------------------------------------------------------------------
// array_regfile
// DEPTH x DSIZE register array.
//   clock, rst_n         : clock, async active-low reset (clears all entries)
//   wr_en/wr_addr/wr_data: single-entry write, updates at the clock edge
//   clr_en/clr_addr      : zero one entry at the edge; a same-cycle write
//                          to the same entry takes priority
//   rd_addr/rd_data      : combinational read of the pre-edge contents
// ---------------------------------------------------------------------------
module array_regfile
    import array_scan_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DSIZE = DEF_DSIZE
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [idx_w(DEPTH)-1:0]  wr_addr,
    input  logic [DSIZE-1:0]         wr_data,
    input  logic                     clr_en,
    input  logic [idx_w(DEPTH)-1:0]  clr_addr,
    input  logic [idx_w(DEPTH)-1:0]  rd_addr,
    output logic [DSIZE-1:0]         rd_data
);

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (clr_en) mem[clr_addr] <= '0;
            // Issued after the clear so the write wins on an address match.
            if (wr_en)  mem[wr_addr]  <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/array_scan_reader.sv
// ---------------------------------------------------------------------------
// array_scan_reader
// Register array with a sequential scan reader. A scan starts at start_idx
// and streams count entries (wrapping modulo DEPTH) over valid/ready, one
// beat per cycle under full throughput.
//   clock, rst_n : clock, async active-low reset (aborts scan, clears array)
//   bus (slave)  : write port, start/start_idx/count, busy/done,
//                  out_valid/out_ready/out_data/out_idx/out_last
// Parameters: DEPTH (power of two), DSIZE, CLR_ON_READ (zero entry on
// its handshake).
// ---------------------------------------------------------------------------
module array_scan_reader
    import array_scan_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DSIZE       = DEF_DSIZE,
    parameter int CLR_ON_READ = 0
) (
    input  logic                clock,
    input  logic                rst_n,
    array_scan_reader_if.slave  bus
);

    localparam int IW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    scan_state_e      state, state_nxt;
    logic [IW-1:0]    idx_q, idx_nxt;     // index of the beat on the bus
    logic [CW-1:0]    rem_q, rem_nxt;     // beats left, including the held one
    logic [DSIZE-1:0] data_q, data_nxt;   // output register

    logic [IW-1:0]    rd_addr;
    logic [DSIZE-1:0] rd_data;
    logic             start_ok;
    logic             hs;
    logic             clr_en;

    assign start_ok = bus.start && (bus.count != '0) && (bus.count <= CW'(DEPTH));
    assign hs       = (state == STREAM) && bus.out_ready;
    assign clr_en   = (CLR_ON_READ != 0) && hs;

    // While idle the read port looks at the requested start entry; while
    // streaming it prefetches the next entry so a handshake can load it
    // straight into the output register.
    assign rd_addr = (state == STREAM) ? idx_q + IW'(1) : bus.start_idx;

    array_regfile #(
        .DEPTH (DEPTH),
        .DSIZE (DSIZE)
    ) u_regfile (
        .clock    (clock),
        .rst_n    (rst_n),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_data  (bus.wr_data),
        .clr_en   (clr_en),
        .clr_addr (idx_q),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        rem_nxt   = rem_q;
        data_nxt  = data_q;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = STREAM;
                    idx_nxt   = bus.start_idx;
                    rem_nxt   = bus.count;
                    data_nxt  = rd_data;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (rem_q == CW'(1)) begin
                        state_nxt = DONE;
                    end else begin
                        // Power-of-two DEPTH: the increment wraps naturally.
                        idx_nxt  = idx_q + IW'(1);
                        rem_nxt  = rem_q - CW'(1);
                        data_nxt = rd_data;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx_q  <= '0;
            rem_q  <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            idx_q  <= idx_nxt;
            rem_q  <= rem_nxt;
            data_q <= data_nxt;
        end
    end

    assign bus.busy      = (state == STREAM);
    assign bus.done      = (state == DONE);
    assign bus.out_valid = (state == STREAM);
    assign bus.out_last  = (state == STREAM) && (rem_q == CW'(1));
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;

endmodule

// File: tb/tb_array_scan_reader.sv
// Two instances share one stimulus stream: u_dut plain, u_clr with
// clear-on-read. Both scan in lockstep, so one pair of reference arrays
// (mem_m / mem_c) predicts both outputs.
module tb_array_scan_reader;

    localparam int DEPTH = 32;
    localparam int DSIZE = 32;
    localparam int IW    = 5;
    localparam int CW    = 6;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    array_scan_reader_if #(.DEPTH(DEPTH), .DSIZE(DSIZE)) b0 ();
    array_scan_reader_if #(.DEPTH(DEPTH), .DSIZE(DSIZE)) b1 ();

    assign b1.wr_en     = b0.wr_en;
    assign b1.wr_addr   = b0.wr_addr;
    assign b1.wr_data   = b0.wr_data;
    assign b1.start     = b0.start;
    assign b1.start_idx = b0.start_idx;
    assign b1.count     = b0.count;
    assign b1.out_ready = b0.out_ready;

    array_scan_reader #(.DEPTH(DEPTH), .DSIZE(DSIZE), .CLR_ON_READ(0)) u_dut (
        .clock (clock), .rst_n (rst_n), .bus (b0.slave));
    array_scan_reader #(.DEPTH(DEPTH), .DSIZE(DSIZE), .CLR_ON_READ(1)) u_clr (
        .clock (clock), .rst_n (rst_n), .bus (b1.slave));

    int tests = 0;
    int fails = 0;
    logic [DSIZE-1:0] mem_m [DEPTH];
    logic [DSIZE-1:0] mem_c [DEPTH];

    typedef struct {
        int          sidx;
        int          cnt;
        logic [31:0] pat;       // out_ready pattern, bit k used on cycle k
        int          exp_last;  // index expected on the out_last beat
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wr(input int a, input logic [DSIZE-1:0] d);
        b0.wr_en = 1'b1; b0.wr_addr = IW'(a); b0.wr_data = d;
        @(negedge clock);
        b0.wr_en = 1'b0;
        mem_m[a] = d;
        mem_c[a] = d;
    endtask

    task automatic expect_beat(input int idx, input logic [DSIZE-1:0] dm,
                               input logic [DSIZE-1:0] dc, input logic last);
        chk("beat_valid", b0.out_valid, 1'b1);
        chk("beat_idx",   b0.out_idx, idx);
        chk("beat_data",  b0.out_data, dm);
        chk("beat_last",  b0.out_last, last);
        chk("clr_valid",  b1.out_valid, 1'b1);
        chk("clr_data",   b1.out_data, dc);
    endtask

    task automatic run_scan(input int sidx, input int cnt, input logic [31:0] pat,
                            input int exp_last);
        int beats, k, cyc, cur;
        logic rdy;
        beats = 0; k = 0; cyc = 0;
        b0.start_idx = IW'(sidx); b0.count = CW'(cnt); b0.start = 1'b1;
        @(negedge clock);
        b0.start = 1'b0;
        while (beats < cnt && cyc < 400) begin
            cur = (sidx + beats) % DEPTH;
            expect_beat(cur, mem_m[cur], mem_c[cur], (beats == cnt - 1));
            chk("scan_busy", b0.busy, 1'b1);
            if (b0.out_last) chk("last_idx", b0.out_idx, exp_last);
            rdy = pat[k % 32];
            k++;
            b0.out_ready = rdy;
            @(negedge clock);
            cyc++;
            if (rdy) begin
                mem_c[cur] = '0;
                beats++;
            end
        end
        b0.out_ready = 1'b0;
        chk("done_pulse", b0.done, 1'b1);
        chk("done_busy",  b0.busy, 1'b0);
        chk("done_valid", b0.out_valid, 1'b0);
        chk("clr_done",   b1.done, 1'b1);
        @(negedge clock);
        chk("done_once",  b0.done, 1'b0);
    endtask

    initial begin
        logic [DSIZE-1:0] e3m, e3c;
        b0.wr_en = 0; b0.wr_addr = '0; b0.wr_data = '0;
        b0.start = 0; b0.start_idx = '0; b0.count = '0; b0.out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin mem_m[i] = '0; mem_c[i] = '0; end

        vecs[0] = '{sidx: 0,  cnt: 32, pat: 32'hFFFF_FFFF, exp_last: 31};
        vecs[1] = '{sidx: 30, cnt: 4,  pat: 32'hFFFF_FFFF, exp_last: 1};
        vecs[2] = '{sidx: 7,  cnt: 5,  pat: 32'h9999_9999, exp_last: 11};
        vecs[3] = '{sidx: 17, cnt: 32, pat: 32'hFFFF_FFFF, exp_last: 16};
        vecs[4] = '{sidx: 31, cnt: 1,  pat: 32'hFFFF_FFFF, exp_last: 31};

        // Reset state
        #1;
        chk("rst_valid", b0.out_valid, 1'b0);
        chk("rst_busy",  b0.busy, 1'b0);
        chk("rst_done",  b0.done, 1'b0);
        chk("rst_last",  b0.out_last, 1'b0);
        chk("rst_data",  b0.out_data, '0);
        chk("rst_idx",   b0.out_idx, '0);
        @(negedge clock); @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < DEPTH; i++) wr(i, DSIZE'(i + 100));

        for (int v = 0; v < 5; v++)
            run_scan(vecs[v].sidx, vecs[v].cnt, vecs[v].pat, vecs[v].exp_last);

        // Write collisions against a held beat, plus a start while busy.
        e3m = mem_m[3]; e3c = mem_c[3];
        b0.start_idx = IW'(2); b0.count = CW'(4); b0.start = 1'b1;
        @(negedge clock);
        b0.start = 1'b0;
        expect_beat(2, mem_m[2], mem_c[2], 1'b0);
        b0.out_ready = 1'b1;
        @(negedge clock);
        mem_c[2] = '0;
        expect_beat(3, e3m, e3c, 1'b0);
        b0.out_ready = 1'b0;
        b0.wr_en = 1'b1; b0.wr_addr = IW'(3); b0.wr_data = 32'hDEAD;
        b0.start = 1'b1; b0.start_idx = IW'(10); b0.count = CW'(1);
        @(negedge clock);
        b0.start = 1'b0;
        mem_m[3] = 32'hDEAD; mem_c[3] = 32'hDEAD;
        expect_beat(3, e3m, e3c, 1'b0);
        chk("coll_busy", b0.busy, 1'b1);
        b0.wr_addr = IW'(5); b0.wr_data = 32'hBEEF;
        @(negedge clock);
        b0.wr_en = 1'b0;
        mem_m[5] = 32'hBEEF; mem_c[5] = 32'hBEEF;
        expect_beat(3, e3m, e3c, 1'b0);
        b0.out_ready = 1'b1;
        @(negedge clock);
        mem_c[3] = '0;
        expect_beat(4, mem_m[4], mem_c[4], 1'b0);
        @(negedge clock);
        mem_c[4] = '0;
        expect_beat(5, 32'hBEEF, 32'hBEEF, 1'b1);
        @(negedge clock);
        mem_c[5] = '0;
        b0.out_ready = 1'b0;
        chk("coll_done",  b0.done, 1'b1);
        chk("coll_dbusy", b0.busy, 1'b0);
        @(negedge clock);
        chk("ign_valid", b0.out_valid, 1'b0);
        chk("ign_busy",  b0.busy, 1'b0);
        run_scan(3, 1, 32'hFFFF_FFFF, 3);

        // Out-of-range counts are ignored.
        for (int c = 0; c < 2; c++) begin
            b0.start_idx = IW'(4); b0.count = (c == 0) ? CW'(0) : CW'(33); b0.start = 1'b1;
            @(negedge clock);
            b0.start = 1'b0;
            chk("badcnt_busy",  b0.busy, 1'b0);
            chk("badcnt_valid", b0.out_valid, 1'b0);
            @(negedge clock);
            chk("badcnt_done",  b0.done, 1'b0);
        end

        // Clear-on-read: first pass returns data, second pass zeros on u_clr.
        for (int i = 0; i < 8; i++) wr(i, DSIZE'(i + 200));
        run_scan(0, 8, 32'hFFFF_FFFF, 7);
        run_scan(0, 8, 32'hFFFF_FFFF, 7);
        // Same-cycle write to the handshaking entry beats the clear.
        b0.start_idx = IW'(4); b0.count = CW'(1); b0.start = 1'b1;
        @(negedge clock);
        b0.start = 1'b0;
        expect_beat(4, mem_m[4], mem_c[4], 1'b1);
        b0.out_ready = 1'b1;
        b0.wr_en = 1'b1; b0.wr_addr = IW'(4); b0.wr_data = 32'h5555;
        @(negedge clock);
        b0.wr_en = 1'b0; b0.out_ready = 1'b0;
        mem_m[4] = 32'h5555; mem_c[4] = 32'h5555;
        chk("wwin_done", b1.done, 1'b1);
        @(negedge clock);
        run_scan(4, 1, 32'hFFFF_FFFF, 4);

        // Async reset during beat 3 of 10.
        b0.start_idx = IW'(0); b0.count = CW'(10); b0.start = 1'b1;
        @(negedge clock);
        b0.start = 1'b0;
        b0.out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_idx", b0.out_idx, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", b0.out_valid, 1'b0);
        chk("arst_busy",  b0.busy, 1'b0);
        chk("arst_done",  b0.done, 1'b0);
        chk("arst_data",  b0.out_data, '0);
        chk("arst_idx",   b0.out_idx, '0);
        chk("arst_last",  b0.out_last, 1'b0);
        b0.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin mem_m[i] = '0; mem_c[i] = '0; end
        @(negedge clock);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("arst_nodone", b0.done, 1'b0);
        end
        run_scan(0, 10, 32'hFFFF_FFFF, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
